// File: rtl/inst_fetch_responder_pkg.sv
// Shared constants and fill FSM encoding for the instruction fetch responder.
package inst_fetch_responder_pkg;

    localparam int          IFR_ADDR_W = 32;
    localparam logic [31:0] IFR_NOP    = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W0_REQ  = 3'd1,
        W0_RESP = 3'd2,
        W1_REQ  = 3'd3,
        W1_RESP = 3'd4
    } fill_state_e;

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Word-wide req/ack/rvalid instruction memory port.
interface inst_fetch_responder_if #(
    parameter int ADDR_W = 32
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/inst_fetch_responder_fsm.sv
// Two-beat doubleword fill sequencer with redirect handling and fill counter.
module inst_fetch_responder_fsm
    import inst_fetch_responder_pkg::*;
#(
    parameter int          ADDR_W       = IFR_ADDR_W,
    parameter logic [31:0] MISS_CNT_RST = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit,
    input  logic [ADDR_W-4:0] fetch_tag,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-4:0] fa,
    output logic              buf_clr,
    output logic              hi_we,
    output logic              fill_done,
    output logic [31:0]       miss_cnt
);

    fill_state_e       state;
    fill_state_e       state_n;
    logic [ADDR_W-4:0] fa_n;
    logic              moved;
    logic              hi_word;

    assign moved    = fetch_tag != fa;
    assign hi_word  = (state == W1_REQ) || (state == W1_RESP);
    assign mem_addr = {fa, hi_word, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fa       <= '0;
            miss_cnt <= MISS_CNT_RST;
        end else begin
            state <= state_n;
            fa    <= fa_n;
            if (fill_done)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    // Accepted requests are never cancelled: a redirect is only acted on
    // before the ack, or when the matching response finally arrives.
    always_comb begin
        state_n   = state;
        fa_n      = fa;
        mem_req   = 1'b0;
        buf_clr   = 1'b0;
        hi_we     = 1'b0;
        fill_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (!hit) begin
                    fa_n    = fetch_tag;
                    buf_clr = 1'b1;
                    state_n = W0_REQ;
                end
            end
            W0_REQ: begin
                mem_req = 1'b1;
                if (mem_ack)
                    state_n = W0_RESP;
                else if (moved)
                    fa_n = fetch_tag;
            end
            W0_RESP: begin
                if (mem_rvalid) begin
                    if (moved) begin
                        fa_n    = fetch_tag;
                        state_n = W0_REQ;
                    end else begin
                        hi_we   = 1'b1;
                        state_n = W1_REQ;
                    end
                end
            end
            W1_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_n = W1_RESP;
                end else if (moved) begin
                    fa_n    = fetch_tag;
                    state_n = W0_REQ;
                end
            end
            W1_RESP: begin
                if (mem_rvalid) begin
                    if (moved) begin
                        fa_n    = fetch_tag;
                        state_n = W0_REQ;
                    end else begin
                        fill_done = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/inst_fetch_responder.sv
// IF fetch port responder: one-entry doubleword buffer with zero-latency hits
// and a two-beat refill from word-wide instruction memory.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int          ADDR_W       = IFR_ADDR_W,
    parameter logic [31:0] NOP_INST     = IFR_NOP,
    parameter logic [31:0] MISS_CNT_RST = 32'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       fetch_addr,
    output logic [63:0]             inst_out,
    output logic                    stall,
    inst_fetch_responder_if.master  mem,
    output logic [31:0]             miss_cnt
);

    logic [63:0]       buf_data;
    logic [ADDR_W-4:0] buf_tag;
    logic              buf_valid;
    logic [ADDR_W-4:0] fetch_tag;
    logic [ADDR_W-4:0] fa;
    logic              hit;
    logic              buf_clr;
    logic              hi_we;
    logic              fill_done;
    logic              unused_low;

    assign fetch_tag  = fetch_addr[ADDR_W-1:3];
    assign unused_low = ^fetch_addr[2:0];

    assign hit      = !rst && buf_valid && (buf_tag == fetch_tag);
    assign stall    = !hit;
    assign inst_out = hit ? buf_data : {NOP_INST, NOP_INST};

    // The high half doubles as staging for the first beat; buf_valid is
    // already low for the whole fill, so it is never observed half-written.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else begin
            if (buf_clr)
                buf_valid <= 1'b0;
            if (hi_we)
                buf_data[63:32] <= mem.mem_rdata;
            if (fill_done) begin
                buf_data[31:0] <= mem.mem_rdata;
                buf_tag        <= fa;
                buf_valid      <= 1'b1;
            end
        end
    end

    inst_fetch_responder_fsm #(
        .ADDR_W       (ADDR_W),
        .MISS_CNT_RST (MISS_CNT_RST)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .hit        (hit),
        .fetch_tag  (fetch_tag),
        .mem_ack    (mem.mem_ack),
        .mem_rvalid (mem.mem_rvalid),
        .mem_req    (mem.mem_req),
        .mem_addr   (mem.mem_addr),
        .fa         (fa),
        .buf_clr    (buf_clr),
        .hi_we      (hi_we),
        .fill_done  (fill_done),
        .miss_cnt   (miss_cnt)
    );

endmodule
